// File: rtl/logic_unit_seq.sv
// Sequential N-bit logic unit: applies a 3-bit opcode W bits per clock, LSB chunk first.
// Optional result flags (zero, parity) are built only when LOGIC_UNIT_SEQ_FLAGS_EN is defined.
module logic_unit_seq #(
  parameter int N = 8,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [2:0]   op,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] y,
  output logic         zero,
  output logic         parity
);

  localparam int C     = N / W;
  localparam int IDX_W = (C > 1) ? $clog2(C) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic [2:0]     op_q, op_d;
  logic [N-1:0]   work_q, work_d;
  logic [N-1:0]   y_q, y_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic [N-1:0]   op_result;
  logic [N-1:0]   chunk_mask;
  logic           last_chunk;

  always_comb begin
    op_result = '0;
    case (op_q)
      3'b000: op_result = a_q & b_q;
      3'b001: op_result = a_q | b_q;
      3'b010: op_result = a_q ^ b_q;
      3'b011: op_result = ~a_q;
      3'b100: op_result = ~(a_q & b_q);
      3'b101: op_result = ~(a_q | b_q);
      3'b110: op_result = ~(a_q ^ b_q);
      3'b111: op_result = a_q;
      default: op_result = '0;
    endcase
  end

  // Selects the W-bit slice handled this cycle; the op is bitwise, so masking is exact.
  always_comb begin
    chunk_mask          = '0;
    chunk_mask[W-1:0]   = '1;
    chunk_mask          = chunk_mask << (int'(idx_q) * W);
  end

  assign last_chunk = (idx_q == IDX_W'(C - 1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    work_d  = work_q;
    y_d     = y_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          op_d    = op;
          work_d  = '0;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        work_d = work_q | (op_result & chunk_mask);
        if (last_chunk) begin
          y_d     = work_d;
          done_d  = 1'b1;
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      work_q  <= '0;
      y_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      work_q  <= work_d;
      y_q     <= y_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign y    = y_q;

`ifdef LOGIC_UNIT_SEQ_FLAGS_EN
  logic zero_q, zero_d;
  logic parity_q, parity_d;

  // Flags track y, so they only move on the completion edge.
  always_comb begin
    zero_d   = zero_q;
    parity_d = parity_q;
    if (done_d) begin
      zero_d   = ~|y_d;
      parity_d = ^y_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q   <= 1'b0;
      parity_q <= 1'b0;
    end else begin
      zero_q   <= zero_d;
      parity_q <= parity_d;
    end
  end

  assign zero   = zero_q;
  assign parity = parity_q;
`else
  assign zero   = 1'b0;
  assign parity = 1'b0;
`endif

endmodule

// File: tb/tb_logic_unit_seq.sv
// Scoreboard bench for logic_unit_seq: an 8-bit/W=2 instance and a 4-bit/W=4 instance.
module tb_logic_unit_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic [2:0] op8 = '0;
  logic       busy8, done8, zero8, parity8;
  logic [7:0] y8;

  logic       start4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic [2:0] op4 = '0;
  logic       busy4, done4, zero4, parity4;
  logic [3:0] y4;

  logic_unit_seq #(.N(8), .W(2)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .op(op8),
    .busy(busy8), .done(done8), .y(y8), .zero(zero8), .parity(parity8)
  );

  logic_unit_seq #(.N(4), .W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .op(op4),
    .busy(busy4), .done(done4), .y(y4), .zero(zero4), .parity(parity4)
  );

  typedef struct {
    logic [7:0] y;
    logic       zero;
    logic       parity;
  } exp_t;

  exp_t q8[$];
  exp_t q4[$];
  int checks = 0;
  int failures = 0;
  logic [7:0] lastY[2] = '{8'h00, 8'h00};

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t makeExp(input logic [7:0] yv);
    exp_t e;
    e.y = yv;
`ifdef LOGIC_UNIT_SEQ_FLAGS_EN
    e.zero   = (yv == 8'h00);
    e.parity = ^yv;
`else
    e.zero   = 1'b0;
    e.parity = 1'b0;
`endif
    return e;
  endfunction

  // Monitor: every done pulse consumes one expected result.
  always @(negedge clk) begin
    exp_t e;
    if (done8) begin
      if (q8.size() == 0) checkOutput("done8 unexpected", 32'd1, 32'd0);
      else begin
        e = q8.pop_front();
        checkOutput("y8", {24'h0, y8}, {24'h0, e.y});
        checkOutput("zero8", {31'h0, zero8}, {31'h0, e.zero});
        checkOutput("parity8", {31'h0, parity8}, {31'h0, e.parity});
      end
    end
    if (done4) begin
      if (q4.size() == 0) checkOutput("done4 unexpected", 32'd1, 32'd0);
      else begin
        e = q4.pop_front();
        checkOutput("y4", {28'h0, y4}, {24'h0, e.y});
        checkOutput("zero4", {31'h0, zero4}, {31'h0, e.zero});
        checkOutput("parity4", {31'h0, parity4}, {31'h0, e.parity});
      end
    end
  end

  // Issues one operation, then scrambles the inputs and tracks busy/done timing.
  task automatic applyStimulus(input int unit, input logic [7:0] a, input logic [7:0] b,
                               input logic [2:0] op, input logic [7:0] expY, input bit poke);
    int c, cnt, doneAt;
    logic busyS, doneS;
    logic [7:0] yS;
    c = (unit == 1) ? 1 : 4;
    @(negedge clk);
    if (unit == 0) begin
      a8 = a; b8 = b; op8 = op; start8 = 1'b1;
      q8.push_back(makeExp(expY));
    end else begin
      a4 = a[3:0]; b4 = b[3:0]; op4 = op; start4 = 1'b1;
      q4.push_back(makeExp(expY));
    end
    @(posedge clk);
    #1;
    start8 = 1'b0; start4 = 1'b0;
    a8 = ~a8; b8 = ~b8; op8 = op8 ^ 3'b101;
    a4 = ~a4; b4 = ~b4; op4 = op4 ^ 3'b101;
    cnt = 0;
    doneAt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      busyS = (unit == 1) ? busy4 : busy8;
      doneS = (unit == 1) ? done4 : done8;
      yS    = (unit == 1) ? {4'h0, y4} : y8;
      if (!busyS) break;
      cnt++;
      if (doneS) doneAt = cnt;
      if (cnt == c) checkOutput("y held during busy", {24'h0, yS}, {24'h0, lastY[unit]});
      if (poke) begin
        start8 = 1'b1; a8 = 8'h00; b8 = 8'h00; op8 = 3'b000;
      end
    end
    start8 = 1'b0;
    checkOutput("busy cycles", cnt, c + 1);
    checkOutput("done position", doneAt, c + 1);
    lastY[unit] = expY;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    checkOutput("reset busy", {31'h0, busy8}, 32'd0);
    checkOutput("reset done", {31'h0, done8}, 32'd0);
    checkOutput("reset y", {24'h0, y8}, 32'd0);
    checkOutput("reset zero", {31'h0, zero8}, 32'd0);
    checkOutput("reset parity", {31'h0, parity8}, 32'd0);
    checkOutput("reset y4", {28'h0, y4}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle busy", {31'h0, busy8}, 32'd0);

    applyStimulus(0, 8'hF0, 8'h3C, 3'b000, 8'h30, 1'b0);
    applyStimulus(0, 8'h00, 8'h55, 3'b011, 8'hFF, 1'b0);
    applyStimulus(0, 8'hA5, 8'hA5, 3'b010, 8'h00, 1'b0);
    applyStimulus(0, 8'hFF, 8'h0F, 3'b001, 8'hFF, 1'b1);
    applyStimulus(0, 8'h12, 8'h40, 3'b101, 8'hAD, 1'b0);
    applyStimulus(0, 8'hF0, 8'h3C, 3'b100, 8'hCF, 1'b0);
    applyStimulus(0, 8'hF0, 8'h3C, 3'b110, 8'h33, 1'b0);
    applyStimulus(0, 8'hF0, 8'h3C, 3'b000, 8'h30, 1'b0);

    // Reset while idx=2 of a PASS A operation.
    @(negedge clk);
    a8 = 8'h81; b8 = 8'h00; op8 = 3'b111; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("y before mid reset", {24'h0, y8}, 32'h30);
    checkOutput("busy before mid reset", {31'h0, busy8}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid reset busy", {31'h0, busy8}, 32'd0);
    checkOutput("mid reset done", {31'h0, done8}, 32'd0);
    checkOutput("mid reset y", {24'h0, y8}, 32'd0);
    checkOutput("mid reset zero", {31'h0, zero8}, 32'd0);
    checkOutput("mid reset parity", {31'h0, parity8}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    lastY[0] = 8'h00;
    @(negedge clk);
    checkOutput("idle after mid reset", {31'h0, busy8}, 32'd0);

    applyStimulus(0, 8'h81, 8'h00, 3'b111, 8'h81, 1'b0);
    applyStimulus(1, 8'h0C, 8'h0A, 3'b100, 8'h07, 1'b0);

    repeat (3) @(negedge clk);
    checkOutput("queue8 drained", q8.size(), 32'd0);
    checkOutput("queue4 drained", q4.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
